// File: rtl/linebuf_bank_median.sv
// Cascaded line-buffer banks for the median filter: executes the controller's
// strobes and presents one aligned vertical pixel column per read beat.
module linebuf_bank_median #(
  parameter int NBANK  = 10,
  parameter int PWIDTH = 7,
  parameter int AWIDTH = 11,
  parameter int MAXW   = 1920
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clken,
  input  logic [10:0]                 width,
  input  logic [PWIDTH-1:0]           pix_in,
  input  logic [NBANK-1:0]            wr_en_n,
  input  logic                        rd_en_n,
  input  logic [AWIDTH-1:0]           wr_addr,
  input  logic [AWIDTH-1:0]           rd_addr,
  input  logic [NBANK-1:0]            valid,
  output logic [(NBANK+1)*PWIDTH-1:0] col_out,
  output logic                        col_valid,
  output logic                        line_end,
  output logic                        addr_err
);

  localparam int CW = 11;
  localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(MAXW);

  logic [PWIDTH-1:0] mem_q   [NBANK][MAXW];
  logic [PWIDTH-1:0] rdata_q [NBANK];
  logic [PWIDTH-1:0] rdata_d [NBANK];
  logic [PWIDTH-1:0] wdata   [NBANK];
  logic [PWIDTH-1:0] pix_d_q;
  logic [NBANK-1:0]  valid_q;
  logic              col_valid_q;
  logic              addr_err_q;
  logic [CW-1:0]     col_cnt_q;

  logic wr_ok, rd_ok, wr_any, last_col;

  assign wr_ok  = {1'b0, wr_addr} < DEPTH;
  assign rd_ok  = {1'b0, rd_addr} < DEPTH;
  assign wr_any = ~&wr_en_n;

  // Each bank above 0 is fed by the registered read output of the bank below.
  always_comb begin
    wdata[0] = pix_in;
    for (int unsigned k = 1; k < NBANK; k++) begin
      wdata[k] = rdata_q[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NBANK; k++) begin
      rdata_d[k] = '0;
      if (rd_ok) begin
        rdata_d[k] = mem_q[k][rd_addr];
      end
    end
  end

  // Storage is not reset; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (clken && wr_ok) begin
      for (int unsigned k = 0; k < NBANK; k++) begin
        if (!wr_en_n[k]) begin
          mem_q[k][wr_addr] <= wdata[k];
        end
      end
    end
  end

  assign last_col = col_valid_q && (col_cnt_q == CW'(width - 11'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NBANK; k++) begin
        rdata_q[k] <= '0;
      end
      pix_d_q     <= '0;
      valid_q     <= '0;
      col_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      col_cnt_q   <= '0;
    end else if (clken) begin
      if (!rd_en_n) begin
        rdata_q <= rdata_d;
        pix_d_q <= pix_in;
        valid_q <= valid;
      end
      col_valid_q <= !rd_en_n;
      if (col_valid_q) begin
        col_cnt_q <= last_col ? '0 : col_cnt_q + CW'(1);
      end
      if ((!rd_en_n && !rd_ok) || (wr_any && !wr_ok)) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    col_out              = '0;
    col_out[PWIDTH-1:0]  = pix_d_q;
    for (int unsigned k = 0; k < NBANK; k++) begin
      if (valid_q[k]) begin
        col_out[(k+1)*PWIDTH +: PWIDTH] = rdata_q[k];
      end
    end
  end

  assign col_valid = col_valid_q;
  assign line_end  = last_col;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_linebuf_bank_median.sv
// Directed bench for linebuf_bank_median: bank writes, cascaded reads, column
// assembly, line_end timing, clock-enable freeze, address errors and reset.
module tb_linebuf_bank_median;

  localparam int NBANK  = 10;
  localparam int PWIDTH = 7;
  localparam int AWIDTH = 11;
  localparam int MAXW   = 1920;
  localparam int COLW   = (NBANK+1)*PWIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              clken;
  logic [10:0]       width;
  logic [PWIDTH-1:0] pix_in;
  logic [NBANK-1:0]  wr_en_n;
  logic              rd_en_n;
  logic [AWIDTH-1:0] wr_addr;
  logic [AWIDTH-1:0] rd_addr;
  logic [NBANK-1:0]  valid;
  logic [COLW-1:0]   col_out;
  logic              col_valid;
  logic              line_end;
  logic              addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  linebuf_bank_median #(
    .NBANK (NBANK),
    .PWIDTH(PWIDTH),
    .AWIDTH(AWIDTH),
    .MAXW  (MAXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clken    (clken),
    .width    (width),
    .pix_in   (pix_in),
    .wr_en_n  (wr_en_n),
    .rd_en_n  (rd_en_n),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .valid    (valid),
    .col_out  (col_out),
    .col_valid(col_valid),
    .line_end (line_end),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLW-1:0] col(input int s0, input int s1, input int s2);
    logic [COLW-1:0] c;
    c = '0;
    c[PWIDTH-1:0]          = PWIDTH'(s0);
    c[2*PWIDTH-1:PWIDTH]   = PWIDTH'(s1);
    c[3*PWIDTH-1:2*PWIDTH] = PWIDTH'(s2);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en_n = 1'b1;
    wr_en_n = '1;
    step();
  endtask

  task automatic rd_beat(input int a, input int p, input logic [COLW-1:0] ec,
                         input logic el, input string tag);
    rd_en_n = 1'b0;
    rd_addr = AWIDTH'(a);
    pix_in  = PWIDTH'(p);
    step();
    check({tag, "_cv"},  col_valid, 1'b1);
    check({tag, "_col"}, col_out,   ec);
    check({tag, "_le"},  line_end,  el);
  endtask

  initial begin
    rst     = 1'b0;
    clken   = 1'b1;
    width   = 11'd4;
    pix_in  = '0;
    wr_en_n = '1;
    rd_en_n = 1'b1;
    wr_addr = '0;
    rd_addr = '0;
    valid   = '0;
    repeat (2) step();
    check("rst_col", col_out,   '0);
    check("rst_cv",  col_valid, 1'b0);
    check("rst_le",  line_end,  1'b0);
    check("rst_err", addr_err,  1'b0);
    rst = 1'b1;
    step();

    // bank 0 gets 1..4, then one line with all banks masked
    for (int i = 0; i < 4; i++) begin
      pix_in  = PWIDTH'(i + 1);
      wr_addr = AWIDTH'(i);
      wr_en_n = ~NBANK'(1);
      step();
      wr_en_n = '1;
    end
    for (int i = 0; i < 4; i++) begin
      rd_beat(i, 5 + i, col(5 + i, 0, 0), i == 3, "l1");
    end
    idle();
    check("l1_idle_cv", col_valid, 1'b0);
    check("l1_idle_le", line_end,  1'b0);

    valid = NBANK'(1);
    for (int i = 0; i < 4; i++) begin
      rd_beat(i, 5 + i, col(5 + i, i + 1, 0), i == 3, "l2");
    end
    idle();

    // bank 1 written one beat behind the read, from bank 0's read output
    for (int i = 0; i < 4; i++) begin
      wr_en_n = (i > 0) ? ~NBANK'(2) : '1;
      wr_addr = AWIDTH'(i - 1);
      rd_beat(i, 5 + i, col(5 + i, i + 1, 0), i == 3, "l3");
    end
    rd_en_n = 1'b1;
    wr_en_n = ~NBANK'(2);
    wr_addr = AWIDTH'(3);
    step();
    idle();

    valid = NBANK'(3);
    for (int i = 0; i < 4; i++) begin
      rd_beat(i, 5 + i, col(5 + i, i + 1, i + 1), i == 3, "l4");
    end
    idle();

    // read-before-write on bank 0 address 2
    valid = NBANK'(1);
    rd_beat(0, 5, col(5, 1, 0), 1'b0, "rw0");
    rd_beat(1, 6, col(6, 2, 0), 1'b0, "rw1");
    wr_en_n = ~NBANK'(1);
    wr_addr = AWIDTH'(2);
    rd_beat(2, 9, col(9, 3, 0), 1'b0, "rw2");
    wr_en_n = '1;
    rd_beat(3, 8, col(8, 4, 0), 1'b1, "rw3");
    idle();

    // clken freeze mid-line; strobes held active must have no effect
    rd_beat(0, 5, col(5, 1, 0), 1'b0, "fz0");
    rd_beat(1, 6, col(6, 2, 0), 1'b0, "fz1");
    clken   = 1'b0;
    rd_en_n = 1'b0;
    rd_addr = AWIDTH'(3);
    pix_in  = PWIDTH'(77);
    wr_en_n = ~NBANK'(1);
    wr_addr = AWIDTH'(0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fz_col", col_out,   col(6, 2, 0));
      check("fz_cv",  col_valid, 1'b1);
      check("fz_le",  line_end,  1'b0);
    end
    wr_en_n = '1;
    clken   = 1'b1;
    rd_beat(2, 7, col(7, 9, 0), 1'b0, "fz2");
    rd_beat(3, 8, col(8, 4, 0), 1'b1, "fz3");
    idle();

    // out-of-range read, then reset at col_cnt=2
    check("err_pre", addr_err, 1'b0);
    rd_beat(MAXW, 10, col(10, 0, 0), 1'b0, "bad");
    check("err_set", addr_err, 1'b1);
    rd_beat(0, 11, col(11, 1, 0), 1'b0, "pr0");
    rd_beat(1, 12, col(12, 2, 0), 1'b0, "pr1");
    check("err_hold", addr_err, 1'b1);
    rd_en_n = 1'b1;
    rst     = 1'b0;
    #2;
    check("ar_cv",  col_valid, 1'b0);
    check("ar_le",  line_end,  1'b0);
    check("ar_col", col_out,   '0);
    check("ar_err", addr_err,  1'b0);
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      rd_beat(i, 20 + i, col(20 + i, (i == 2) ? 9 : i + 1, 0), i == 3, "pr");
    end
    idle();
    check("end_err", addr_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
